// File: rtl/up_pkg.sv
// Shared definitions for the 4-bit microprocessor: opcodes, ALU/bus encodings,
// control-unit states and the EXEC control word.
package up_pkg;

  localparam logic [3:0] OP_JC    = 4'h0;
  localparam logic [3:0] OP_JNC   = 4'h1;
  localparam logic [3:0] OP_CMPI  = 4'h2;
  localparam logic [3:0] OP_CMPM  = 4'h3;
  localparam logic [3:0] OP_LIT   = 4'h4;
  localparam logic [3:0] OP_IN    = 4'h5;
  localparam logic [3:0] OP_LD    = 4'h6;
  localparam logic [3:0] OP_ST    = 4'h7;
  localparam logic [3:0] OP_JZ    = 4'h8;
  localparam logic [3:0] OP_JNZ   = 4'h9;
  localparam logic [3:0] OP_ADDI  = 4'hA;
  localparam logic [3:0] OP_ADDM  = 4'hB;
  localparam logic [3:0] OP_JMP   = 4'hC;
  localparam logic [3:0] OP_OUT   = 4'hD;
  localparam logic [3:0] OP_NANDI = 4'hE;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic [1:0] {
    ALU_PASS = 2'b00,
    ALU_SUB  = 2'b01,
    ALU_ADD  = 2'b10,
    ALU_NAND = 2'b11
  } alu_fn_e;

  typedef enum logic [1:0] {
    SRC_OPRND = 2'b00,
    SRC_RAM   = 2'b01,
    SRC_INP   = 2'b10,
    SRC_ACC   = 2'b11
  } src_sel_e;

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_EXEC  = 2'b01,
    ST_HALT  = 2'b10
  } state_e;

  typedef struct packed {
    logic     en_counter;
    logic     load;
    logic     load_acc;
    logic     load_flags;
    logic     cs_ram;
    logic     we_ram;
    logic     load_out;
    alu_fn_e  alu_fn;
    src_sel_e src_sel;
  } ctrl_t;

endpackage

// File: rtl/decode_rom.sv
// Combinational opcode decoder: {instr, carry, zero} -> EXEC-phase control word.
module decode_rom
  import up_pkg::*;
(
  input  logic [3:0] i_instr,
  input  logic       i_carry,
  input  logic       i_zero,
  output ctrl_t      o_ctrl
);

  logic w_taken;

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    o_ctrl  = '0;
    w_taken = 1'b0;
    case (i_instr)
      OP_JC, OP_JNC, OP_JZ, OP_JNZ, OP_JMP: begin
        case (i_instr)
          OP_JC:   w_taken = i_carry;
          OP_JNC:  w_taken = ~i_carry;
          OP_JZ:   w_taken = i_zero;
          OP_JNZ:  w_taken = ~i_zero;
          default: w_taken = 1'b1;
        endcase
        // An untaken jump still has to step over its address byte.
        o_ctrl.load       = w_taken;
        o_ctrl.en_counter = ~w_taken;
      end
      OP_CMPI: begin
        o_ctrl.alu_fn     = ALU_SUB;
        o_ctrl.src_sel    = SRC_OPRND;
        o_ctrl.load_flags = 1'b1;
      end
      OP_CMPM: begin
        o_ctrl.alu_fn     = ALU_SUB;
        o_ctrl.src_sel    = SRC_RAM;
        o_ctrl.cs_ram     = 1'b1;
        o_ctrl.load_flags = 1'b1;
        o_ctrl.en_counter = 1'b1;
      end
      OP_LIT: begin
        o_ctrl.alu_fn   = ALU_PASS;
        o_ctrl.src_sel  = SRC_OPRND;
        o_ctrl.load_acc = 1'b1;
      end
      OP_IN: begin
        o_ctrl.alu_fn   = ALU_PASS;
        o_ctrl.src_sel  = SRC_INP;
        o_ctrl.load_acc = 1'b1;
      end
      OP_LD: begin
        o_ctrl.alu_fn     = ALU_PASS;
        o_ctrl.src_sel    = SRC_RAM;
        o_ctrl.cs_ram     = 1'b1;
        o_ctrl.load_acc   = 1'b1;
        o_ctrl.en_counter = 1'b1;
      end
      OP_ST: begin
        o_ctrl.src_sel    = SRC_ACC;
        o_ctrl.cs_ram     = 1'b1;
        o_ctrl.we_ram     = 1'b1;
        o_ctrl.en_counter = 1'b1;
      end
      OP_ADDI: begin
        o_ctrl.alu_fn     = ALU_ADD;
        o_ctrl.src_sel    = SRC_OPRND;
        o_ctrl.load_acc   = 1'b1;
        o_ctrl.load_flags = 1'b1;
      end
      OP_ADDM: begin
        o_ctrl.alu_fn     = ALU_ADD;
        o_ctrl.src_sel    = SRC_RAM;
        o_ctrl.cs_ram     = 1'b1;
        o_ctrl.load_acc   = 1'b1;
        o_ctrl.load_flags = 1'b1;
        o_ctrl.en_counter = 1'b1;
      end
      OP_OUT: begin
        o_ctrl.src_sel  = SRC_ACC;
        o_ctrl.load_out = 1'b1;
      end
      OP_NANDI: begin
        o_ctrl.alu_fn     = ALU_NAND;
        o_ctrl.src_sel    = SRC_OPRND;
        o_ctrl.load_acc   = 1'b1;
        o_ctrl.load_flags = 1'b1;
      end
      default: ; // HALT / NOP: no strobes in EXEC
    endcase
  end

endmodule

// File: rtl/decode_control.sv
// Two-phase FETCH/EXEC control unit with retired-instruction counter.
// Define DECODE_HALT_EN to make opcode F enter a reset-only HALT state.
module decode_control
  import up_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       instr,
  input  logic             carry,
  input  logic             zero,
  output logic             eneable_counter,
  output logic             load,
  output logic             eneable_fetch,
  output logic             load_acc,
  output logic             load_flags,
  output logic [1:0]       alu_fn,
  output logic [1:0]       src_sel,
  output logic             cs_ram,
  output logic             we_ram,
  output logic             load_out,
  output logic             phase,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  state_e           r_state;
  state_e           w_next;
  ctrl_t            w_ctrl;
  logic [CNT_W-1:0] r_retired;

  decode_rom u_rom (
    .i_instr (instr),
    .i_carry (carry),
    .i_zero  (zero),
    .o_ctrl  (w_ctrl)
  );

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      r_state   <= ST_FETCH;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_EXEC) r_retired <= r_retired + 1'b1;
    end
  end

  always_comb begin
    w_next = ST_FETCH;
    case (r_state)
      ST_FETCH: w_next = ST_EXEC;
`ifdef DECODE_HALT_EN
      ST_EXEC:  w_next = (instr == OP_HALT) ? ST_HALT : ST_FETCH;
      ST_HALT:  w_next = ST_HALT;
`else
      ST_EXEC:  w_next = ST_FETCH;
`endif
      default:  w_next = ST_FETCH;
    endcase
  end

  always_comb begin
    eneable_counter = 1'b0;
    load            = 1'b0;
    eneable_fetch   = 1'b0;
    load_acc        = 1'b0;
    load_flags      = 1'b0;
    alu_fn          = ALU_PASS;
    src_sel         = SRC_OPRND;
    cs_ram          = 1'b0;
    we_ram          = 1'b0;
    load_out        = 1'b0;
    case (r_state)
      ST_FETCH: begin
        eneable_fetch   = 1'b1;
        eneable_counter = 1'b1;
      end
      ST_EXEC: begin
        eneable_counter = w_ctrl.en_counter;
        load            = w_ctrl.load;
        load_acc        = w_ctrl.load_acc;
        load_flags      = w_ctrl.load_flags;
        alu_fn          = w_ctrl.alu_fn;
        src_sel         = w_ctrl.src_sel;
        cs_ram          = w_ctrl.cs_ram;
        we_ram          = w_ctrl.we_ram;
        load_out        = w_ctrl.load_out;
      end
      default: ; // HALT freezes the datapath
    endcase
  end

  assign phase   = (r_state == ST_EXEC);
  assign retired = r_retired;
`ifdef DECODE_HALT_EN
  assign halted  = (r_state == ST_HALT);
`else
  assign halted  = 1'b0;
`endif

endmodule

// File: tb/tb_decode_control.sv
// Directed self-checking bench for decode_control; follows DECODE_HALT_EN if defined.
module tb_decode_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  instr;
  logic        carry, zero;
  logic        eneable_counter, load, eneable_fetch, load_acc, load_flags;
  logic [1:0]  alu_fn, src_sel;
  logic        cs_ram, we_ram, load_out, phase, halted;
  logic [15:0] retired;

  // Narrow-counter instance used only to reach the wrap point quickly.
  logic        reset2;
  logic [3:0]  instr2;
  logic        ec2, ld2, ef2, la2, lf2, cs2, we2, lo2, ph2, ht2;
  logic [1:0]  alu2, src2;
  logic [3:0]  retired2;

  int n_checks = 0;
  int n_fail   = 0;
  int n_instr  = 0;

  always #5 clk = ~clk;

  decode_control #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .instr(instr), .carry(carry), .zero(zero),
    .eneable_counter(eneable_counter), .load(load), .eneable_fetch(eneable_fetch),
    .load_acc(load_acc), .load_flags(load_flags), .alu_fn(alu_fn), .src_sel(src_sel),
    .cs_ram(cs_ram), .we_ram(we_ram), .load_out(load_out), .phase(phase),
    .halted(halted), .retired(retired)
  );

  decode_control #(.CNT_W(4)) dut_wrap (
    .clk(clk), .reset(reset2), .instr(instr2), .carry(1'b0), .zero(1'b0),
    .eneable_counter(ec2), .load(ld2), .eneable_fetch(ef2),
    .load_acc(la2), .load_flags(lf2), .alu_fn(alu2), .src_sel(src2),
    .cs_ram(cs2), .we_ram(we2), .load_out(lo2), .phase(ph2),
    .halted(ht2), .retired(retired2)
  );

  // Strobe vector order: {eneable_counter, load, eneable_fetch, load_acc, load_flags, cs_ram, we_ram, load_out}
  localparam logic [7:0] S_FETCH = 8'b1010_0000;
  localparam logic [7:0] S_NONE  = 8'b0000_0000;

  function automatic logic [7:0] strobes();
    return {eneable_counter, load, eneable_fetch, load_acc, load_flags, cs_ram, we_ram, load_out};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [3:0] op;
    logic       c;
    logic       z;
    logic [7:0] stb;
    logic [1:0] alu;
    logic [1:0] src;
  } vec_t;

  vec_t vecs [20];

  initial begin
    vecs = '{
      '{4'h0, 1'b1, 1'b0, 8'b0100_0000, 2'b00, 2'b00},  // JC taken
      '{4'h0, 1'b0, 1'b0, 8'b1000_0000, 2'b00, 2'b00},  // JC not taken
      '{4'h1, 1'b0, 1'b1, 8'b0100_0000, 2'b00, 2'b00},  // JNC taken
      '{4'h1, 1'b1, 1'b0, 8'b1000_0000, 2'b00, 2'b00},  // JNC not taken
      '{4'h8, 1'b0, 1'b1, 8'b0100_0000, 2'b00, 2'b00},  // JZ taken
      '{4'h8, 1'b1, 1'b0, 8'b1000_0000, 2'b00, 2'b00},  // JZ not taken
      '{4'h9, 1'b1, 1'b0, 8'b0100_0000, 2'b00, 2'b00},  // JNZ taken
      '{4'h9, 1'b0, 1'b1, 8'b1000_0000, 2'b00, 2'b00},  // JNZ not taken
      '{4'hC, 1'b0, 1'b0, 8'b0100_0000, 2'b00, 2'b00},  // JMP
      '{4'hC, 1'b1, 1'b1, 8'b0100_0000, 2'b00, 2'b00},  // JMP with flags set
      '{4'h2, 1'b1, 1'b1, 8'b0000_1000, 2'b01, 2'b00},  // CMPI
      '{4'h3, 1'b0, 1'b0, 8'b1000_1100, 2'b01, 2'b01},  // CMPM
      '{4'h4, 1'b0, 1'b0, 8'b0001_0000, 2'b00, 2'b00},  // LIT
      '{4'h5, 1'b0, 1'b0, 8'b0001_0000, 2'b00, 2'b10},  // IN
      '{4'h6, 1'b0, 1'b0, 8'b1001_0100, 2'b00, 2'b01},  // LD
      '{4'h7, 1'b0, 1'b0, 8'b1000_0110, 2'b00, 2'b11},  // ST
      '{4'hA, 1'b0, 1'b0, 8'b0001_1000, 2'b10, 2'b00},  // ADDI
      '{4'hB, 1'b0, 1'b0, 8'b1001_1100, 2'b10, 2'b01},  // ADDM
      '{4'hD, 1'b0, 1'b0, 8'b0000_0001, 2'b00, 2'b11},  // OUT
      '{4'hE, 1'b0, 1'b0, 8'b0001_1000, 2'b11, 2'b00}   // NANDI
    };

    reset = 1'b1; instr = 4'h4; carry = 1'b0; zero = 1'b0;
    reset2 = 1'b1; instr2 = 4'h4;

    // Reset state, held across clock edges.
    repeat (2) @(negedge clk);
    check("reset_strobes", strobes(), S_FETCH);
    check("reset_alu_src", {alu_fn, src_sel}, 4'h0);
    check("reset_phase", phase, 1'b0);
    check("reset_halted", halted, 1'b0);
    check("reset_retired", retired, 16'h0);

    // LIT: FETCH then EXEC.
    reset = 1'b0;
    #1;
    check("lit_fetch", strobes(), S_FETCH);
    @(negedge clk);
    check("lit_exec_strobes", strobes(), 8'b0001_0000);
    check("lit_exec_alu_src", {alu_fn, src_sel}, 4'h0);
    check("lit_exec_phase", phase, 1'b1);
    check("lit_exec_retired", retired, 16'h0);
    n_instr++;
    @(negedge clk);
    check("lit_retired", retired, 16'h1);
    check("lit_back_fetch", strobes(), S_FETCH);

    // Table of opcodes and flag combinations.
    foreach (vecs[i]) begin
      instr = vecs[i].op; carry = vecs[i].c; zero = vecs[i].z;
      @(negedge clk);
      check($sformatf("op%0h_c%0d_z%0d_strobes", vecs[i].op, vecs[i].c, vecs[i].z), strobes(), vecs[i].stb);
      check($sformatf("op%0h_alu_src", vecs[i].op), {alu_fn, src_sel}, {vecs[i].alu, vecs[i].src});
      check($sformatf("op%0h_not_both", vecs[i].op), eneable_counter & load, 1'b0);
      n_instr++;
      @(negedge clk);
      check($sformatf("op%0h_fetch", vecs[i].op), strobes(), S_FETCH);
      check($sformatf("op%0h_retired", vecs[i].op), retired, n_instr);
    end

    // Opcode F.
    instr = 4'hF; carry = 1'b0; zero = 1'b0;
    @(negedge clk);
    check("opF_exec_strobes", strobes(), S_NONE);
    check("opF_exec_phase", phase, 1'b1);
    n_instr++;
    @(negedge clk);
`ifdef DECODE_HALT_EN
    for (int k = 0; k < 20; k++) begin
      check("halt_halted", halted, 1'b1);
      check("halt_strobes", strobes(), S_NONE);
      check("halt_retired", retired, n_instr);
      @(negedge clk);
    end
`else
    check("nop_halted", halted, 1'b0);
    check("nop_fetch", strobes(), S_FETCH);
    check("nop_retired", retired, n_instr);
    @(negedge clk);
    check("nop_exec_again", phase, 1'b1);
    @(negedge clk);
`endif

    // Reset clears everything (and is the only exit from HALT).
    reset = 1'b1;
    #1;
    check("rst2_strobes", strobes(), S_FETCH);
    check("rst2_halted", halted, 1'b0);
    check("rst2_retired", retired, 16'h0);
    @(negedge clk);
    reset = 1'b0;
    instr = 4'hB;
    @(negedge clk);
    check("addm_exec_strobes", strobes(), 8'b1001_1100);
    check("addm_exec_alu_src", {alu_fn, src_sel}, 4'b1001);
    reset = 1'b1;
    #1;
    check("addm_abort_strobes", strobes(), S_FETCH);
    check("addm_abort_phase", phase, 1'b0);
    check("addm_abort_retired", retired, 16'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("after_abort_fetch", strobes(), S_FETCH);

    // Counter wrap on the 4-bit instance: 15 instructions, then one more.
    @(negedge clk);
    reset2 = 1'b0;
    repeat (30) @(negedge clk);
    check("wrap_pre", retired2, 4'hF);
    repeat (2) @(negedge clk);
    check("wrap_zero", retired2, 4'h0);
    check("wrap_fetch", {ec2, ld2, ef2, la2, lf2, cs2, we2, lo2}, S_FETCH);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
